// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: assembles strobed serial bits into N-bit words (MSB first)
// and offers each finished word on a valid/ready handshake. It also flags
// inter-bit timeout and overrun, and counts delivered frames.
// Build option: define PARITY_CHECK_EN to expect a trailing even-parity bit
// per frame and report mismatches on par_err (otherwise par_err is tied low).
module sipo_frame_ctrl #(
  parameter int N       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         frame_start,
  input  logic         sin,
  input  logic         bit_valid,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         overrun,
  output logic         timeout_err,
  output logic         par_err,
  input  logic         err_clr,
  output logic [15:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  // Index of the bit that completes a frame (parity bit follows the data).
`ifdef PARITY_CHECK_EN
  localparam int LAST_IDX = N;
`else
  localparam int LAST_IDX = N - 1;
`endif
  localparam int CW = $clog2(N + 1);
  localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(LAST_IDX);
  localparam logic [GW-1:0] GAP_LAST = (TIMEOUT > 0) ? GW'(TIMEOUT - 1) : '0;

  state_t        state, state_nx;
  logic [N-1:0]  sr, sr_nx, dout_nx, shifted;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic [GW-1:0] gap_cnt, gap_cnt_nx;
  logic [15:0]   frame_cnt_nx;
  logic          dout_valid_nx;
  logic          begin_frame;
  logic          overrun_set, timeout_set;
`ifdef PARITY_CHECK_EN
  logic          par_acc, par_acc_nx, par_set;
`endif

  assign shifted = {sr[N-2:0], sin};

  // Next-state and datapath decode for the IDLE / SHIFT / HOLD sequencer.
  always_comb begin
    // NOTE: every variable gets a default here so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_nx      = state;
    sr_nx         = sr;
    bit_cnt_nx    = bit_cnt;
    gap_cnt_nx    = gap_cnt;
    dout_nx       = dout;
    dout_valid_nx = dout_valid;
    frame_cnt_nx  = frame_cnt;
    begin_frame   = 1'b0;
    overrun_set   = 1'b0;
    timeout_set   = 1'b0;
`ifdef PARITY_CHECK_EN
    par_acc_nx    = par_acc;
    par_set       = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (frame_start) begin_frame = 1'b1;
      end

      SHIFT: begin
        if (frame_start) begin
          begin_frame = 1'b1;
        end else if (bit_valid) begin
          gap_cnt_nx = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nx      = HOLD;
            dout_valid_nx = 1'b1;
            frame_cnt_nx  = frame_cnt + 16'd1;
            bit_cnt_nx    = '0;
`ifdef PARITY_CHECK_EN
            // Final bit is the parity bit: it checks the word but is not stored.
            dout_nx = sr;
            par_set = par_acc ^ sin;
`else
            dout_nx = shifted;
            sr_nx   = shifted;
`endif
          end else begin
            sr_nx      = shifted;
            bit_cnt_nx = bit_cnt + CW'(1);
`ifdef PARITY_CHECK_EN
            par_acc_nx = par_acc ^ sin;
`endif
          end
        end else if (TIMEOUT != 0) begin
          if (gap_cnt == GAP_LAST) begin
            // Gap limit reached: abandon the partial frame, leave dout alone.
            state_nx    = IDLE;
            timeout_set = 1'b1;
            sr_nx       = '0;
            bit_cnt_nx  = '0;
            gap_cnt_nx  = '0;
          end else begin
            gap_cnt_nx = gap_cnt + GW'(1);
          end
        end
      end

      HOLD: begin
        if (dout_ready) begin
          dout_valid_nx = 1'b0;
          if (frame_start) begin_frame = 1'b1;
          else             state_nx    = IDLE;
        end else if (frame_start) begin
          overrun_set = 1'b1;
        end
        // A bit is only usable here when it opens a back-to-back frame.
        if (bit_valid && !(dout_ready && frame_start)) overrun_set = 1'b1;
      end

      default: state_nx = IDLE;
    endcase

    // Common frame (re)start; a same-cycle bit becomes bit 0.
    if (begin_frame) begin
      state_nx   = SHIFT;
      gap_cnt_nx = '0;
      bit_cnt_nx = bit_valid ? CW'(1) : '0;
      if (bit_valid) sr_nx = shifted;
`ifdef PARITY_CHECK_EN
      par_acc_nx = bit_valid & sin;
`endif
    end
  end

  // State, datapath and sticky-flag registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
`ifdef PARITY_CHECK_EN
      par_acc     <= 1'b0;
      par_err     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state       <= state_nx;
      sr          <= sr_nx;
      bit_cnt     <= bit_cnt_nx;
      gap_cnt     <= gap_cnt_nx;
      dout        <= dout_nx;
      dout_valid  <= dout_valid_nx;
      busy        <= (state_nx != IDLE);
      frame_cnt   <= frame_cnt_nx;
      // Sticky flags: a set event outranks a same-cycle clear.
      overrun     <= overrun_set | (overrun & ~err_clr);
      timeout_err <= timeout_set | (timeout_err & ~err_clr);
`ifdef PARITY_CHECK_EN
      par_acc     <= par_acc_nx;
      par_err     <= par_set | (par_err & ~err_clr);
`endif
    end
  end

`ifndef PARITY_CHECK_EN
  assign par_err = 1'b0;
`endif

endmodule
